reaction_timer_fsm: RTL and testbench
=====================================

// Module: reaction_timer_fsm
// PURPOSE
// Producer side of the 14-bit time_millisecs display interface.
// Sequences one reaction trial: idle, 3-2-1 countdown, random hold-off, stimulus LED, then measured response.
// Outputs either a numeric millisecond value or a reserved code (`IDLE, `LED_BLANK, `FAIL) to the SSD time decoder.
// Sits between the debounced button pulses and the SSD time decoder.
// PARAMETERS
// MIN_DELAY_MS   1000   minimum hold-off after countdown, in ms
// RAND_BITS      11     LFSR bits added to hold-off (0..2^RAND_BITS-1 ms)
// COUNT_STEP_MS  1000   duration of each countdown digit, in ms
// TIMEOUT_MS     9999   max reaction time; reaching it = FAIL
// LFSR_SEED      16'hACE1  non-zero LFSR reset value
// PORTS
// clock             in   1   system clock
// reset_n           in   1   asynchronous, active-low reset
// rising_edge_1khz  in   1   one-clock strobe, 1 kHz, the ms timebase
// start_pulse       in   1   debounced start button, one-clock pulse
// react_pulse       in   1   debounced react button, one-clock pulse
// time_millisecs    out  14  numeric ms (0..9999) or `IDLE/`LED_BLANK/`FAIL
// stimulus_led      out  1   high while awaiting reaction
// result_valid      out  1   one-clock pulse when a numeric result is latched
// BEHAVIOUR
// - Reset: state=S_IDLE, time_millisecs=`IDLE, stimulus_led=0, result_valid=0, counters=0, LFSR=LFSR_SEED.
//   Reset asserted mid-trial aborts to S_IDLE immediately.
// - All outputs are registered. Response to a pulse appears one clock after the pulse.
// - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clock, never all-zero.
// - S_IDLE: output `IDLE. start_pulse -> S_COUNT, with digit=3 and ms_cnt=0.
// - S_COUNT: output digit*1000 (3000/2000/1000); ms_cnt increments on each strobe.
//   At ms_cnt==COUNT_STEP_MS-1 with strobe: ms_cnt=0, digit decrements.
//   On digit 1 expiry: load delay=MIN_DELAY_MS+lfsr[RAND_BITS-1:0], go S_HOLD.
//   react_pulse -> S_FAIL.
// - S_HOLD: output `LED_BLANK; delay decrements on each strobe.
//   Strobe with delay==1 -> S_REACT, ms_cnt=0, stimulus_led=1.
//   react_pulse -> S_FAIL (early press).
// - S_REACT: output ms_cnt live; ms_cnt increments on each strobe.
//   react_pulse -> S_RESULT: latch current ms_cnt (pre-increment if a strobe coincides), result_valid=1 for one clock, led=0.
//   ms_cnt reaches TIMEOUT_MS -> S_FAIL.
// - S_RESULT: hold the latched value. S_FAIL: output `FAIL, led=0.
//   From either state, start_pulse -> S_COUNT (new trial).
// - Ignored pulses:
//   start_pulse during S_COUNT/S_HOLD/S_REACT.
//   react_pulse in S_IDLE/S_RESULT/S_FAIL.
// - Simultaneous start and react: start takes priority in S_IDLE/S_RESULT/S_FAIL; react takes priority elsewhere.
// - Widths: ms_cnt 14b, saturates at TIMEOUT_MS; delay 14b; digit 2b.
//   Numeric outputs never exceed 9999, so they never alias the reserved codes.
// STRUCTURE
// - Shared header reaction_timer_defs.vh holds:
//   reserved codes `FAIL=14'h3FFF, `IDLE=14'h3FFE, `LED_BLANK=14'h3FFD;
//   state encodings S_IDLE..S_FAIL (3b).
//   The SSD time decoder includes the same header.
// - One sub-module: reaction_lfsr (16-bit Galois LFSR, seed parameter, free-running).
// TESTING
// 1. Reset, then start_pulse -> time_millisecs 3000, 2000, 1000 at 1000-strobe intervals; then `LED_BLANK.
// 2. Force LFSR low bits =0 -> LED on exactly 1000 strobes after `LED_BLANK.
//    react after 237 strobes -> time=237, result_valid one clock, led=0.
// 3. react_pulse during S_HOLD -> `FAIL next clock, led stays 0; start_pulse -> 3000.
// 4. No react in S_REACT -> `FAIL on reaching 9999, led=0.
// 5. react and strobe same clock at ms_cnt=500 -> latched 500.
//    start+react together in S_RESULT -> restart with 3000.
// 6. Assert reset_n low mid-S_REACT -> async `IDLE, led=0; start ignored while in reset.

Source files
------------

// File: rtl/reaction_timer_fsm_pkg.sv
// ---------------------------------------------------------------------------
// reaction_timer_fsm_pkg
// Shared definitions for the reaction timer and the SSD time decoder:
//   - reserved 14-bit display codes (never produced as numeric values,
//     since numeric results are capped at 9999)
//   - trial state type
//   - LFSR step and countdown-digit helpers
// ---------------------------------------------------------------------------
package reaction_timer_fsm_pkg;

    localparam logic [13:0] CODE_FAIL      = 14'h3FFF;
    localparam logic [13:0] CODE_IDLE      = 14'h3FFE;
    localparam logic [13:0] CODE_LED_BLANK = 14'h3FFD;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_HOLD   = 3'd2,
        S_REACT  = 3'd3,
        S_RESULT = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Countdown display value: 3 -> 3000, 2 -> 2000, 1 -> 1000
    function automatic logic [13:0] digit_ms(input logic [1:0] digit);
        return 14'(digit) * 14'd1000;
    endfunction

endpackage

// File: rtl/reaction_timer_fsm_lfsr.sv
// ---------------------------------------------------------------------------
// reaction_lfsr
// Free-running 16-bit Galois LFSR used to randomise the hold-off delay.
// Advances every clock; a non-zero seed keeps it out of the all-zero lockup.
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset (loads SEED)
//   value    out  low OUT_BITS bits of the LFSR state
// ---------------------------------------------------------------------------
module reaction_lfsr
    import reaction_timer_fsm_pkg::*;
#(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int unsigned OUT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic [OUT_BITS-1:0] value
);

    logic [15:0] state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

    assign value = state[OUT_BITS-1:0];

endmodule

// File: rtl/reaction_timer_fsm.sv
// ---------------------------------------------------------------------------
// reaction_timer_fsm
// Sequences one reaction trial: idle, 3-2-1 countdown, random hold-off,
// stimulus LED, measured response. Drives the 14-bit time_millisecs display
// interface with either a numeric ms value (0..9999) or a reserved code.
// Ports:
//   clock             in   system clock
//   reset_n           in   asynchronous active-low reset
//   rising_edge_1khz  in   one-clock 1 kHz strobe (ms timebase)
//   start_pulse       in   debounced start button pulse
//   react_pulse       in   debounced react button pulse
//   time_millisecs    out  numeric ms or CODE_IDLE/CODE_LED_BLANK/CODE_FAIL
//   stimulus_led      out  high while awaiting the reaction
//   result_valid      out  one-clock pulse when a numeric result is latched
// All outputs are registered.
// ---------------------------------------------------------------------------
module reaction_timer_fsm
    import reaction_timer_fsm_pkg::*;
#(
    parameter int unsigned MIN_DELAY_MS  = 1000,
    parameter int unsigned RAND_BITS     = 11,
    parameter int unsigned COUNT_STEP_MS = 1000,
    parameter int unsigned TIMEOUT_MS    = 9999,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rising_edge_1khz,
    input  logic        start_pulse,
    input  logic        react_pulse,
    output logic [13:0] time_millisecs,
    output logic        stimulus_led,
    output logic        result_valid
);

    localparam logic [13:0] STEP_LAST    = 14'(COUNT_STEP_MS - 1);
    localparam logic [13:0] MIN_DELAY    = 14'(MIN_DELAY_MS);
    localparam logic [13:0] TIMEOUT      = 14'(TIMEOUT_MS);
    localparam logic [13:0] TIMEOUT_LAST = 14'(TIMEOUT_MS - 1);

    state_t                 state;
    logic [13:0]            ms_cnt;
    logic [13:0]            delay;
    logic [1:0]             digit;
    logic [RAND_BITS-1:0]   rand_bits;

    reaction_lfsr #(
        .SEED     (LFSR_SEED),
        .OUT_BITS (RAND_BITS)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .value   (rand_bits)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ms_cnt         <= '0;
            delay          <= '0;
            digit          <= '0;
            time_millisecs <= CODE_IDLE;
            stimulus_led   <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                // Terminal/idle states: start wins over a simultaneous react
                S_IDLE, S_RESULT, S_FAIL: begin
                    if (start_pulse) begin
                        state          <= S_COUNT;
                        digit          <= 2'd3;
                        ms_cnt         <= '0;
                        time_millisecs <= digit_ms(2'd3);
                        stimulus_led   <= 1'b0;
                    end
                end

                S_COUNT: begin
                    if (react_pulse) begin
                        state          <= S_FAIL;
                        time_millisecs <= CODE_FAIL;
                    end else if (rising_edge_1khz) begin
                        if (ms_cnt == STEP_LAST) begin
                            ms_cnt <= '0;
                            if (digit == 2'd1) begin
                                digit          <= '0;
                                delay          <= MIN_DELAY + 14'(rand_bits);
                                state          <= S_HOLD;
                                time_millisecs <= CODE_LED_BLANK;
                            end else begin
                                digit          <= digit - 2'd1;
                                time_millisecs <= digit_ms(digit - 2'd1);
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 14'd1;
                        end
                    end
                end

                S_HOLD: begin
                    if (react_pulse) begin
                        state          <= S_FAIL;
                        time_millisecs <= CODE_FAIL;
                    end else if (rising_edge_1khz) begin
                        delay <= delay - 14'd1;
                        if (delay == 14'd1) begin
                            state          <= S_REACT;
                            ms_cnt         <= '0;
                            time_millisecs <= '0;
                            stimulus_led   <= 1'b1;
                        end
                    end
                end

                S_REACT: begin
                    // React takes the pre-increment count even if a strobe coincides
                    if (react_pulse) begin
                        state          <= S_RESULT;
                        time_millisecs <= ms_cnt;
                        result_valid   <= 1'b1;
                        stimulus_led   <= 1'b0;
                    end else if (rising_edge_1khz) begin
                        if (ms_cnt >= TIMEOUT_LAST) begin
                            state          <= S_FAIL;
                            ms_cnt         <= TIMEOUT;
                            time_millisecs <= CODE_FAIL;
                            stimulus_led   <= 1'b0;
                        end else begin
                            ms_cnt         <= ms_cnt + 14'd1;
                            time_millisecs <= ms_cnt + 14'd1;
                        end
                    end
                end

                default: begin
                    state          <= S_IDLE;
                    time_millisecs <= CODE_IDLE;
                    stimulus_led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_fsm.sv
module tb_reaction_timer_fsm;

    localparam logic [13:0] T_FAIL  = 14'h3FFF;
    localparam logic [13:0] T_IDLE  = 14'h3FFE;
    localparam logic [13:0] T_BLANK = 14'h3FFD;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAIL = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rising_edge_1khz = 1'b0;
    logic        start_pulse = 1'b0;
    logic        react_pulse = 1'b0;
    logic [13:0] time_millisecs;
    logic        stimulus_led;
    logic        result_valid;

    int checks = 0;
    int failures = 0;

    // Trial-level reference model: one count of strobes since start decides
    // countdown digit, hold-off and reaction time arithmetically.
    int          m_state;
    int          m_elapsed;
    int          m_delay;
    int          m_result;
    bit          m_valid;
    logic [15:0] m_lfsr;

    reaction_timer_fsm #(
        .MIN_DELAY_MS  (1000),
        .RAND_BITS     (11),
        .COUNT_STEP_MS (1000),
        .TIMEOUT_MS    (9999),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .rising_edge_1khz (rising_edge_1khz),
        .start_pulse      (start_pulse),
        .react_pulse      (react_pulse),
        .time_millisecs   (time_millisecs),
        .stimulus_led     (stimulus_led),
        .result_valid     (result_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state   = M_IDLE;
        m_elapsed = 0;
        m_delay   = 0;
        m_result  = 0;
        m_valid   = 1'b0;
        m_lfsr    = 16'hACE1;
    endtask

    task automatic model_edge(input bit s, input bit st, input bit rc);
        logic [15:0] pre;
        if (!reset_n) return;
        pre     = m_lfsr;
        m_lfsr  = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_valid = 1'b0;
        if (m_state != M_RUN) begin
            if (st) begin
                m_state   = M_RUN;
                m_elapsed = 0;
            end
        end else if (rc) begin
            if (m_elapsed >= 3000 + m_delay) begin
                m_result = m_elapsed - 3000 - m_delay;
                m_state  = M_DONE;
                m_valid  = 1'b1;
            end else begin
                m_state = M_FAIL;
            end
        end else if (s) begin
            m_elapsed++;
            if (m_elapsed == 3000) m_delay = 1000 + int'(pre & 16'h07FF);
            if (m_elapsed >= 3000 && m_elapsed - 3000 - m_delay >= 9999) m_state = M_FAIL;
        end
    endtask

    function automatic logic [13:0] exp_time();
        case (m_state)
            M_IDLE: return T_IDLE;
            M_FAIL: return T_FAIL;
            M_DONE: return 14'(m_result);
            default: begin
                if (m_elapsed < 3000) return 14'((3 - m_elapsed / 1000) * 1000);
                else if (m_elapsed < 3000 + m_delay) return T_BLANK;
                else return 14'(m_elapsed - 3000 - m_delay);
            end
        endcase
    endfunction

    function automatic bit exp_led();
        return (m_state == M_RUN) && (m_elapsed >= 3000) && (m_elapsed >= 3000 + m_delay);
    endfunction

    // Drive one clock: inputs applied at negedge, model updated at posedge,
    // returns at the next negedge where outputs are sampled.
    task automatic step(input bit s, input bit st, input bit rc);
        rising_edge_1khz = s;
        start_pulse      = st;
        react_pulse      = rc;
        @(posedge clock);
        model_edge(s, st, rc);
        @(negedge clock);
        rising_edge_1khz = 1'b0;
        start_pulse      = 1'b0;
        react_pulse      = 1'b0;
    endtask

    task automatic advance_to_led();
        for (int i = 0; i < 20000 && !exp_led(); i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (time_millisecs !== T_IDLE) begin
            failures++; $display("FAIL reset_time: got %h expected %h", time_millisecs, T_IDLE);
        end
        checks++;
        if (stimulus_led !== 1'b0 || result_valid !== 1'b0) begin
            failures++; $display("FAIL reset_outputs: led=%b valid=%b expected 0/0", stimulus_led, result_valid);
        end
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (time_millisecs !== T_IDLE) begin
            failures++; $display("FAIL idle_ignores_react: got %h expected %h", time_millisecs, T_IDLE);
        end
    endtask

    task automatic test_countdown();
        logic [13:0] exp;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (time_millisecs !== 14'd3000) begin
            failures++; $display("FAIL countdown_start: got %0d expected 3000", time_millisecs);
        end
        for (int d = 3; d >= 1; d--) begin
            for (int i = 0; i < 999; i++) step(1'b1, (i == 500), 1'b0);
            checks++;
            if (time_millisecs !== 14'(d * 1000)) begin
                failures++; $display("FAIL countdown_digit_hold: got %0d expected %0d", time_millisecs, d * 1000);
            end
            step(1'b1, 1'b0, 1'b0);
            exp = (d == 1) ? T_BLANK : 14'((d - 1) * 1000);
            checks++;
            if (time_millisecs !== exp) begin
                failures++; $display("FAIL countdown_digit_change: got %h expected %h", time_millisecs, exp);
            end
        end
        checks++;
        if (stimulus_led !== 1'b0) begin
            failures++; $display("FAIL countdown_led: got %b expected 0", stimulus_led);
        end
    endtask

    task automatic test_hold_and_react();
        int n;
        bit s;
        n = 0;
        while (!exp_led() && n < 20000) begin
            s = ($urandom_range(0, 3) != 0);
            step(s, 1'b0, 1'b0);
            checks++;
            if (stimulus_led !== exp_led() || time_millisecs !== exp_time()) begin
                failures++;
                $display("FAIL hold_track: led=%b time=%h expected led=%b time=%h", stimulus_led, time_millisecs, exp_led(), exp_time());
            end
            n++;
        end
        if (n >= 20000) begin
            checks++; failures++; $display("FAIL hold_timeout: led never expected within bound");
        end
        checks++;
        if (stimulus_led !== 1'b1 || time_millisecs !== 14'd0) begin
            failures++; $display("FAIL led_on: led=%b time=%0d expected 1/0", stimulus_led, time_millisecs);
        end
        n = 0;
        for (int i = 0; i < 5000 && n < 237; i++) begin
            s = $urandom_range(0, 1) != 0;
            step(s, 1'b0, 1'b0);
            if (s) n++;
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (time_millisecs !== 14'd237 || result_valid !== 1'b1 || stimulus_led !== 1'b0) begin
            failures++;
            $display("FAIL react_237: time=%0d valid=%b led=%b expected 237/1/0", time_millisecs, result_valid, stimulus_led);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (time_millisecs !== 14'd237 || result_valid !== 1'b0) begin
            failures++; $display("FAIL result_hold: time=%0d valid=%b expected 237/0", time_millisecs, result_valid);
        end
    endtask

    task automatic test_early_react();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) step(1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 900)) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (time_millisecs !== T_FAIL || stimulus_led !== 1'b0) begin
            failures++; $display("FAIL early_react: time=%h led=%b expected %h/0", time_millisecs, stimulus_led, T_FAIL);
        end
        repeat (3) step(1'b1, 1'b0, 1'b1);
        checks++;
        if (time_millisecs !== T_FAIL) begin
            failures++; $display("FAIL fail_hold: got %h expected %h", time_millisecs, T_FAIL);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (time_millisecs !== 14'd3000) begin
            failures++; $display("FAIL restart_from_fail: got %0d expected 3000", time_millisecs);
        end
    endtask

    task automatic test_timeout();
        logic [13:0] prev;
        int n;
        prev = '0;
        n = 0;
        while (m_state == M_RUN && n < 20000) begin
            prev = time_millisecs;
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (n >= 20000) begin
            checks++; failures++; $display("FAIL timeout_bound: trial never ended within bound");
        end
        checks++;
        if (prev !== 14'd9998) begin
            failures++; $display("FAIL timeout_last_value: got %0d expected 9998", prev);
        end
        checks++;
        if (time_millisecs !== T_FAIL || stimulus_led !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout: time=%h led=%b valid=%b expected %h/0/0", time_millisecs, stimulus_led, result_valid, T_FAIL);
        end
    endtask

    task automatic test_coincident();
        step(1'b0, 1'b1, 1'b0);
        advance_to_led();
        repeat (500) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (time_millisecs !== 14'd500) begin
            failures++; $display("FAIL live_500: got %0d expected 500", time_millisecs);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (time_millisecs !== 14'd500 || result_valid !== 1'b1) begin
            failures++; $display("FAIL react_with_strobe: time=%0d valid=%b expected 500/1", time_millisecs, result_valid);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (time_millisecs !== 14'd3000 || result_valid !== 1'b0) begin
            failures++; $display("FAIL start_react_in_result: time=%0d valid=%b expected 3000/0", time_millisecs, result_valid);
        end
    endtask

    task automatic test_reset_mid_react();
        advance_to_led();
        repeat (40) step(1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (time_millisecs !== T_IDLE || stimulus_led !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: time=%h led=%b valid=%b expected %h/0/0", time_millisecs, stimulus_led, result_valid, T_IDLE);
        end
        @(negedge clock);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (time_millisecs !== T_IDLE) begin
            failures++; $display("FAIL start_in_reset: got %h expected %h", time_millisecs, T_IDLE);
        end
        reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (time_millisecs !== 14'd3000) begin
            failures++; $display("FAIL start_after_reset: got %0d expected 3000", time_millisecs);
        end
        for (int i = 0; i < 20000 && !exp_led(); i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (stimulus_led !== exp_led() || time_millisecs !== exp_time()) begin
                failures++;
                $display("FAIL reseed_track: led=%b time=%h expected led=%b time=%h", stimulus_led, time_millisecs, exp_led(), exp_time());
            end
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random_trials();
        int target;
        int n;
        bit s, st, rc;
        for (int t = 0; t < 2; t++) begin
            target = $urandom_range(50, 400);
            step(1'b0, 1'b1, 1'b0);
            n = 0;
            while (m_state == M_RUN && n < 40000) begin
                s  = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 2999) == 0);
                rc = (exp_led() && (m_elapsed - 3000 - m_delay) >= target) || ($urandom_range(0, 19999) == 0);
                step(s, st, rc);
                checks++;
                if (time_millisecs !== exp_time() || stimulus_led !== exp_led() || result_valid !== m_valid) begin
                    failures++;
                    $display("FAIL random_trial: time=%h led=%b valid=%b expected time=%h led=%b valid=%b",
                             time_millisecs, stimulus_led, result_valid, exp_time(), exp_led(), m_valid);
                end
                n++;
            end
            if (n >= 40000) begin
                checks++; failures++; $display("FAIL random_trial_bound: trial never ended within bound");
            end
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (time_millisecs !== exp_time() || result_valid !== 1'b0) begin
                failures++; $display("FAIL random_trial_end: time=%h valid=%b expected time=%h valid=0", time_millisecs, result_valid, exp_time());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_hold_and_react();
        test_early_react();
        test_timeout();
        test_coincident();
        test_reset_mid_react();
        test_random_trials();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
